sigma_alu_decode: RTL and testbench
===================================

Name: sigma_alu_decode

Overview:
- Decode-side producer of ALU operation codes.
- Accepts raw 32-bit RV32I instruction words on a valid/ready stream. Decodes OP (0110011) and OP-IMM (0010011) instructions into the shared 4-bit ALU op encoding, register indices, immediate and control flags.
- Presents the result through a registered, 2-entry skid-buffered output stream to the execute stage, which feeds the ALU.
- Sits between fetch and execute.

Parameters:
- XLEN, 32, datapath/immediate width.
- CNT_W, 16, width of saturating illegal-instruction counter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  drop all buffered entries; ignore input this cycle.
- in_valid  input  1  instruction word valid.
- in_ready  output  1  decoder can accept; registered.
- in_instr  input  32  instruction word.
- out_valid  output  1  decoded entry valid.
- out_ready  input  1  execute stage accepts.
- out_alu_op  output  4  ALU op code (ADD/SUB/AND/OR/XOR/SLL/SRL/SRA).
- out_rs1  output  5  source register 1.
- out_rs2  output  5  source register 2 (0 when use_imm).
- out_rd  output  5  destination register.
- out_imm  output  XLEN  immediate operand.
- out_use_imm  output  1  operand B = imm.
- out_reg_write  output  1  write rd.
- out_illegal  output  1  unsupported/illegal encoding.
- illegal_count  output  CNT_W  saturating count of illegal entries accepted.

Behaviour:
- Reset (rst sampled high at posedge):
  - out_valid=0; all out_* fields=0; skid empty; in_ready=1; illegal_count=0.
  - Input is ignored in the reset cycle.
- Transfers:
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
  - Latency 1 cycle: an accepted word appears on out_* at the next edge if the output register is empty or draining.
- States:
  - EMPTY: out_valid=0, skid empty. Accept → BUSY.
  - BUSY: output register full, skid empty.
    - Accept and drain together → BUSY (new entry loaded).
    - Accept without drain → FULL (entry to skid).
    - Drain only → EMPTY.
  - FULL: both full, in_ready=0.
    - Drain → BUSY (skid moves to output).
- in_ready is registered and equals "skid empty" for the next cycle. No combinational path from out_ready to in_ready.
- Order is strictly FIFO. No loss, no duplication. Output fields are stable while out_valid && !out_ready.
- flush (priority over everything except rst):
  - Next cycle: out_valid=0, skid empty, in_ready=1.
  - Any same-cycle input is discarded.
  - illegal_count is not affected by the discarded word.
- Decode, OP:
  - funct3 000 with funct7 0000000 → ADD; with funct7 0100000 → SUB.
  - 001 → SLL; 100 → XOR; 101 → SRL (funct7 0000000) or SRA (funct7 0100000); 110 → OR; 111 → AND.
  - funct7 must be 0000000 except SUB/SRA.
  - use_imm=0, imm=0.
- Decode, OP-IMM:
  - Same funct3 map with immediate: ADDI/SLLI/XORI/SRLI/SRAI/ORI/ANDI.
  - imm = sign-extended instr[31:20], except shifts: imm = zero-extended instr[24:20], and instr[31:25] must be 0000000 (SRAI: 0100000).
  - rs2=0, use_imm=1.
- Unsupported (illegal=1):
  - funct3 010/011 (SLT/SLTU), bad funct7/shift imm, or any other opcode.
  - Entry still passes through with alu_op=ALU_ADD, reg_write=0, rs1/rs2/rd/imm=0.
- rd=0 legal instruction: reg_write=0.
- illegal_count increments on accepted illegal words only; saturates at all-ones.
- Reset asserted mid-stream discards all entries.

Decomposition:
- Add to sigma_pkg:
  - opcode constants OPC_OP, OPC_OP_IMM.
  - funct3 constants F3_ADD, F3_SLL, F3_SLT, F3_SLTU, F3_XOR, F3_SR, F3_OR, F3_AND.
  - funct7 constants F7_BASE, F7_ALT.
  - packed struct decode_t {alu_op, rs1, rs2, rd, imm, use_imm, reg_write, illegal}.
- ALU_* codes are reused from the package; no local redefinition.
- One sub-module: sigma_skid_buffer (generic, WIDTH parameter, 2-entry registered valid/ready), carrying decode_t.
- Combinational decode function lives in sigma_alu_decode.

Test Plan:
- add x3,x1,x2 (0x002081B3), out_ready=1 → next cycle out_valid=1, alu_op=0000, rs1=1, rs2=2, rd=3, use_imm=0, reg_write=1, illegal=0.
- sub x5,x6,x7 (0x407302B3) then srai x1,x2,3 (0x40315093) back-to-back → alu_op 0001 (rs1=6, rs2=7, rd=5), then alu_op 0111 (imm=3, use_imm=1, rs2=0); addi x1,x0,-1 (0xFFF00093) → ADD, imm=0xFFFFFFFF.
- slt x1,x2,x3 (0x003120B3) and opcode 0x6F word → both illegal=1, reg_write=0, alu_op=0000; illegal_count=2.
- out_ready=0, push A,B,C → A in output, B in skid, in_ready=0, C held; raise out_ready → A,B,C emerge in order, one per cycle, fields stable while stalled.
- FULL state + flush with in_valid=1 → next cycle out_valid=0, in_ready=1, nothing emerges, illegal_count unchanged.
- rst asserted in BUSY → next cycle out_valid=0, in_ready=1, illegal_count=0; force counter to all-ones, send illegal word → stays all-ones.

Source files
------------

// File: rtl/sigma_pkg.sv
// Shared decode-side definitions: ALU op codes, RV32I field constants,
// the decoded-entry record and the skid buffer state encoding.
package sigma_pkg;

    localparam int DATA_W = 32;

    // ALU operation encoding shared by decode and execute
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;

    // Major opcodes handled by this decoder
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // funct3 values
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct7 values: base form and the SUB/SRA alternate form
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [3:0]        alu_op;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [DATA_W-1:0] imm;
        logic              use_imm;
        logic              reg_write;
        logic              illegal;
    } decode_t;

    // Occupancy of the 2-entry skid buffer
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_BUSY  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/sigma_skid_buffer.sv
// Generic 2-entry registered skid buffer.
// Handshake: a transfer happens on a side when its valid and ready are both
// high at the rising edge; valid holds and data stays stable until accepted.
// in_ready_o is a register (true when the skid slot will be empty), so there
// is no combinational path from out_ready_i to in_ready_o.
module sigma_skid_buffer
    import sigma_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output skid_state_t      state_o
);

    skid_state_t      state_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] skid_data_q;
    logic             push;
    logic             pop;

    assign push = in_valid_i && in_ready_q;
    assign pop  = out_valid_q && out_ready_i;

    // Occupancy FSM; valid/ready are kept as registers alongside the state
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            state_q     <= SKID_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_data_q  <= '0;
            skid_data_q <= '0;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (push) begin
                        out_data_q  <= in_data_i;
                        out_valid_q <= 1'b1;
                        state_q     <= SKID_BUSY;
                    end
                end
                SKID_BUSY: begin
                    if (push && pop) begin
                        out_data_q <= in_data_i;
                    end else if (push) begin
                        skid_data_q <= in_data_i;
                        in_ready_q  <= 1'b0;
                        state_q     <= SKID_FULL;
                    end else if (pop) begin
                        out_valid_q <= 1'b0;
                        state_q     <= SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (pop) begin
                        out_data_q <= skid_data_q;
                        in_ready_q <= 1'b1;
                        state_q    <= SKID_BUSY;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= SKID_EMPTY;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign state_o     = state_q;

endmodule

// File: rtl/sigma_alu_decode.sv
// Decodes RV32I OP / OP-IMM words into ALU op records and streams them to
// execute through a 2-entry skid buffer. Counts accepted illegal words.
module sigma_alu_decode
    import sigma_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_alu_op,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_use_imm,
    output logic             out_reg_write,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count,
    output skid_state_t      dbg_state
);

    // Pure decode of one instruction word; unsupported words become an
    // illegal ADD with every other field cleared.
    function automatic decode_t decode(input logic [31:0] instr);
        decode_t    d;
        logic [6:0] opcode;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       legal;
        logic [3:0] op;
        logic       is_imm;
        logic [DATA_W-1:0] imm;

        opcode = instr[6:0];
        f3     = instr[14:12];
        f7     = instr[31:25];
        legal  = 1'b0;
        op     = ALU_ADD;
        is_imm = 1'b0;
        imm    = '0;

        if (opcode == OPC_OP) begin
            case (f3)
                F3_ADD: begin
                    if (f7 == F7_BASE) begin legal = 1'b1; op = ALU_ADD; end
                    else if (f7 == F7_ALT) begin legal = 1'b1; op = ALU_SUB; end
                end
                F3_SLL: begin legal = (f7 == F7_BASE); op = ALU_SLL; end
                F3_XOR: begin legal = (f7 == F7_BASE); op = ALU_XOR; end
                F3_SR: begin
                    if (f7 == F7_BASE) begin legal = 1'b1; op = ALU_SRL; end
                    else if (f7 == F7_ALT) begin legal = 1'b1; op = ALU_SRA; end
                end
                F3_OR:  begin legal = (f7 == F7_BASE); op = ALU_OR;  end
                F3_AND: begin legal = (f7 == F7_BASE); op = ALU_AND; end
                default: legal = 1'b0;  // SLT / SLTU not supported
            endcase
        end else if (opcode == OPC_OP_IMM) begin
            is_imm = 1'b1;
            imm    = {{(DATA_W-12){instr[31]}}, instr[31:20]};
            case (f3)
                F3_ADD: begin legal = 1'b1; op = ALU_ADD; end
                F3_XOR: begin legal = 1'b1; op = ALU_XOR; end
                F3_OR:  begin legal = 1'b1; op = ALU_OR;  end
                F3_AND: begin legal = 1'b1; op = ALU_AND; end
                F3_SLL: begin
                    legal = (f7 == F7_BASE);
                    op    = ALU_SLL;
                    imm   = {{(DATA_W-5){1'b0}}, instr[24:20]};
                end
                F3_SR: begin
                    imm = {{(DATA_W-5){1'b0}}, instr[24:20]};
                    if (f7 == F7_BASE) begin legal = 1'b1; op = ALU_SRL; end
                    else if (f7 == F7_ALT) begin legal = 1'b1; op = ALU_SRA; end
                end
                default: legal = 1'b0;  // SLTI / SLTIU not supported
            endcase
        end

        d = '0;
        d.alu_op = ALU_ADD;
        if (legal) begin
            d.alu_op    = op;
            d.rs1       = instr[19:15];
            d.rs2       = is_imm ? 5'd0 : instr[24:20];
            d.rd        = instr[11:7];
            d.imm       = imm;
            d.use_imm   = is_imm;
            d.reg_write = (instr[11:7] != 5'd0);
        end else begin
            d.illegal = 1'b1;
        end
        return d;
    endfunction

    decode_t          dec_w;
    decode_t          out_w;
    logic             skid_in_ready;
    logic [CNT_W-1:0] illegal_cnt_q;
    logic [CNT_W-1:0] illegal_cnt_d;
    logic             accept;

    assign dec_w  = decode(in_instr);
    assign accept = in_valid && skid_in_ready && !flush;

    // Saturating increment for accepted illegal words
    always_comb begin
        illegal_cnt_d = illegal_cnt_q;
        if (accept && dec_w.illegal && (illegal_cnt_q != {CNT_W{1'b1}})) begin
            illegal_cnt_d = illegal_cnt_q + 1'b1;
        end
    end

    // Illegal-word counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_cnt_q <= '0;
        end else begin
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    sigma_skid_buffer #(
        .WIDTH ($bits(decode_t))
    ) u_skid (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (skid_in_ready),
        .in_data_i   (dec_w),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_w),
        .state_o     (dbg_state)
    );

    assign in_ready      = skid_in_ready;
    assign out_alu_op    = out_w.alu_op;
    assign out_rs1       = out_w.rs1;
    assign out_rs2       = out_w.rs2;
    assign out_rd        = out_w.rd;
    assign out_imm       = out_w.imm;
    assign out_use_imm   = out_w.use_imm;
    assign out_reg_write = out_w.reg_write;
    assign out_illegal   = out_w.illegal;
    assign illegal_count = illegal_cnt_q;

endmodule

// File: tb/tb_sigma_alu_decode.sv
// Directed bench for sigma_alu_decode. A second instance with a 3-bit
// counter shares the stimulus so counter saturation is reachable quickly.
module tb_sigma_alu_decode;
    import sigma_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;

    logic        in_ready, out_valid;
    logic [3:0]  out_alu_op;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [31:0] out_imm;
    logic        out_use_imm, out_reg_write, out_illegal;
    logic [15:0] illegal_count;
    skid_state_t dbg_state;

    logic        s_in_ready, s_out_valid;
    logic [3:0]  s_alu_op;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic [31:0] s_imm;
    logic        s_use_imm, s_reg_write, s_illegal;
    logic [2:0]  s_count;
    skid_state_t s_state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sigma_alu_decode u_dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_alu_op    (out_alu_op),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_rd        (out_rd),
        .out_imm       (out_imm),
        .out_use_imm   (out_use_imm),
        .out_reg_write (out_reg_write),
        .out_illegal   (out_illegal),
        .illegal_count (illegal_count),
        .dbg_state     (dbg_state)
    );

    sigma_alu_decode #(.CNT_W(3)) u_dut_sat (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (s_in_ready),
        .in_instr      (in_instr),
        .out_valid     (s_out_valid),
        .out_ready     (out_ready),
        .out_alu_op    (s_alu_op),
        .out_rs1       (s_rs1),
        .out_rs2       (s_rs2),
        .out_rd        (s_rd),
        .out_imm       (s_imm),
        .out_use_imm   (s_use_imm),
        .out_reg_write (s_reg_write),
        .out_illegal   (s_illegal),
        .illegal_count (s_count),
        .dbg_state     (s_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Expected output record, in the same field order as the observed pack
    function automatic logic [63:0] rec(input logic [3:0] op, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [4:0] rd,
                                        input logic [31:0] imm, input logic ui,
                                        input logic rw, input logic ill);
        return 64'({op, rs1, rs2, rd, imm, ui, rw, ill});
    endfunction

    function automatic logic [63:0] obs_rec();
        return 64'({out_alu_op, out_rs1, out_rs2, out_rd, out_imm,
                    out_use_imm, out_reg_write, out_illegal});
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I_ADD  = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] I_SUB  = 32'h407302B3; // sub  x5,x6,x7
    localparam logic [31:0] I_SRAI = 32'h40315093; // srai x1,x2,3
    localparam logic [31:0] I_ADDI = 32'hFFF00093; // addi x1,x0,-1
    localparam logic [31:0] I_SLLI = 32'h01F29213; // slli x4,x5,31
    localparam logic [31:0] I_ANDI = 32'h7FF47393; // andi x7,x8,2047
    localparam logic [31:0] I_ADD0 = 32'h00208033; // add  x0,x1,x2
    localparam logic [31:0] I_SLT  = 32'h003120B3; // slt  x1,x2,x3
    localparam logic [31:0] I_JAL  = 32'h0000006F; // jal  x0,0
    localparam logic [31:0] I_MUL  = 32'h022081B3; // mul  x3,x1,x2 (bad funct7)
    localparam logic [31:0] I_OR   = 32'h003160B3; // or   x1,x2,x3
    localparam logic [31:0] I_XOR  = 32'h0062C233; // xor  x4,x5,x6
    localparam logic [31:0] I_SRL  = 32'h009453B3; // srl  x7,x8,x9

    initial begin
        // Reset with a live illegal word on the input, which must be ignored
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_instr = I_SLT; out_ready = 1'b1;
        cycle();
        cycle();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_count", 64'(illegal_count), 64'd0);
        check("rst_fields", obs_rec(), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(SKID_EMPTY));

        // add, then sub/srai/addi back-to-back with out_ready=1
        rst = 1'b0; in_instr = I_ADD;
        cycle();
        check("add_valid", 64'(out_valid), 64'd1);
        check("add_rec", obs_rec(), rec(ALU_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b1, 1'b0));
        in_instr = I_SUB;
        cycle();
        check("sub_rec", obs_rec(), rec(ALU_SUB, 5'd6, 5'd7, 5'd5, 32'd0, 1'b0, 1'b1, 1'b0));
        in_instr = I_SRAI;
        cycle();
        check("srai_rec", obs_rec(), rec(ALU_SRA, 5'd2, 5'd0, 5'd1, 32'd3, 1'b1, 1'b1, 1'b0));
        in_instr = I_ADDI;
        cycle();
        check("addi_rec", obs_rec(), rec(ALU_ADD, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0));
        in_instr = I_SLLI;
        cycle();
        check("slli_rec", obs_rec(), rec(ALU_SLL, 5'd5, 5'd0, 5'd4, 32'd31, 1'b1, 1'b1, 1'b0));
        in_instr = I_ANDI;
        cycle();
        check("andi_rec", obs_rec(), rec(ALU_AND, 5'd8, 5'd0, 5'd7, 32'h7FF, 1'b1, 1'b1, 1'b0));
        in_instr = I_ADD0;
        cycle();
        check("add_rd0_rec", obs_rec(), rec(ALU_ADD, 5'd1, 5'd2, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0));

        // Illegal words still pass through, cleared to an illegal ADD
        in_instr = I_SLT;
        cycle();
        check("slt_rec", obs_rec(), rec(ALU_ADD, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1));
        check("slt_count", 64'(illegal_count), 64'd1);
        in_instr = I_JAL;
        cycle();
        check("jal_rec", obs_rec(), rec(ALU_ADD, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1));
        check("jal_count", 64'(illegal_count), 64'd2);
        in_instr = I_MUL;
        cycle();
        check("mul_rec", obs_rec(), rec(ALU_ADD, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1));
        check("mul_count", 64'(illegal_count), 64'd3);
        in_valid = 1'b0;
        cycle();
        check("drain_valid", 64'(out_valid), 64'd0);

        // Backpressure: A to output, B to skid, C held off
        out_ready = 1'b0; in_valid = 1'b1; in_instr = I_OR;
        cycle();
        check("bp_a_state", 64'(dbg_state), 64'(SKID_BUSY));
        in_instr = I_XOR;
        cycle();
        check("bp_full_ready", 64'(in_ready), 64'd0);
        check("bp_full_state", 64'(dbg_state), 64'(SKID_FULL));
        check("bp_a_rec", obs_rec(), rec(ALU_OR, 5'd2, 5'd3, 5'd1, 32'd0, 1'b0, 1'b1, 1'b0));
        in_instr = I_SRL;
        cycle();
        check("bp_a_stable", obs_rec(), rec(ALU_OR, 5'd2, 5'd3, 5'd1, 32'd0, 1'b0, 1'b1, 1'b0));
        check("bp_held_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        cycle();
        check("bp_b_rec", obs_rec(), rec(ALU_XOR, 5'd5, 5'd6, 5'd4, 32'd0, 1'b0, 1'b1, 1'b0));
        check("bp_b_ready", 64'(in_ready), 64'd1);
        cycle();
        check("bp_c_valid", 64'(out_valid), 64'd1);
        check("bp_c_rec", obs_rec(), rec(ALU_SRL, 5'd8, 5'd9, 5'd7, 32'd0, 1'b0, 1'b1, 1'b0));
        in_valid = 1'b0;
        cycle();
        check("bp_empty_valid", 64'(out_valid), 64'd0);

        // Flush from FULL with an illegal word offered in the same cycle
        out_ready = 1'b0; in_valid = 1'b1; in_instr = I_OR;
        cycle();
        in_instr = I_XOR;
        cycle();
        check("fl_pre_state", 64'(dbg_state), 64'(SKID_FULL));
        flush = 1'b1; in_instr = I_SLT;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ready", 64'(in_ready), 64'd1);
        check("fl_count", 64'(illegal_count), 64'd3);
        out_ready = 1'b1;
        cycle();
        check("fl_nothing_1", 64'(out_valid), 64'd0);
        cycle();
        check("fl_nothing_2", 64'(out_valid), 64'd0);

        // Reset while BUSY discards the entry and clears the counter
        out_ready = 1'b0; in_valid = 1'b1; in_instr = I_ADD;
        cycle();
        check("rb_busy", 64'(dbg_state), 64'(SKID_BUSY));
        in_valid = 1'b0; rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rb_valid", 64'(out_valid), 64'd0);
        check("rb_ready", 64'(in_ready), 64'd1);
        check("rb_count", 64'(illegal_count), 64'd0);
        check("rb_count_small", 64'(s_count), 64'd0);

        // Counter saturation on the 3-bit instance: 9 illegal words
        out_ready = 1'b1; in_valid = 1'b1; in_instr = I_JAL;
        for (int i = 0; i < 7; i++) cycle();
        check("sat_at_max", 64'(s_count), 64'd7);
        cycle();
        cycle();
        in_valid = 1'b0;
        check("sat_held", 64'(s_count), 64'd7);
        check("sat_wide_count", 64'(illegal_count), 64'd9);
        check("sat_small_illegal", 64'(s_illegal), 64'd1);
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
